// File: rtl/tcdm_slave_mem_pkg.sv
// Shared types and helpers for the banked TCDM responder.
// - bank_sel_w / row_w: address-field widths derived from the bank geometry.
// - tcdm_req_t / tcdm_rsp_t: per-port request payload and response.
// - StallLfsrTaps: feedback taps of the optional per-port stall LFSR.
package tcdm_slave_mem_pkg;

    // Number of address bits that select a bank (0 for a single bank).
    function automatic int unsigned bank_sel_w(input int unsigned nb_banks);
        return (nb_banks > 1) ? $clog2(nb_banks) : 0;
    endfunction

    // Index width for a bank's row address; kept at least 1 bit wide.
    function automatic int unsigned row_w(input int unsigned bank_words);
        return (bank_words > 1) ? $clog2(bank_words) : 1;
    endfunction

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } tcdm_req_t;

    typedef struct packed {
        logic [31:0] r_data;
        logic        r_valid;
    } tcdm_rsp_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0].
    localparam logic [15:0] StallLfsrTaps = 16'hB400;

endpackage

// File: rtl/tcdm_slave_mem_if.sv
// TCDM bus bundle for MP ports.
// master modport: drives req/add/wen/be/data, receives gnt/r_data/r_valid.
// slave modport:  the memory side, mirror of master.
interface tcdm_slave_mem_if #(
    parameter int unsigned MP = 2
);
    logic [MP-1:0]       req;
    logic [MP-1:0]       gnt;
    logic [MP-1:0][31:0] add;
    logic [MP-1:0]       wen;
    logic [MP-1:0][3:0]  be;
    logic [MP-1:0][31:0] data;
    logic [MP-1:0][31:0] r_data;
    logic [MP-1:0]       r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );
endinterface

// File: rtl/tcdm_slave_mem_bank.sv
// One memory bank: MP-way round-robin arbiter plus BANK_WORDS x 32 storage.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset (clears rr pointer only)
//   req_i         : per-port request already filtered to this bank
//   reqs_i        : all ports' request payloads
//   win_o         : one-hot winner (zero when no request)
//   rdata_o       : storage word at the winner's row (combinational)
module tcdm_slave_mem_bank
    import tcdm_slave_mem_pkg::*;
#(
    parameter int unsigned MP         = 2,
    parameter int unsigned NB_BANKS   = 4,
    parameter int unsigned BANK_WORDS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic      [MP-1:0]   req_i,
    input  tcdm_req_t [MP-1:0]   reqs_i,
    output logic      [MP-1:0]   win_o,
    output logic      [31:0]     rdata_o
);
    localparam int unsigned PtrW  = (MP > 1) ? $clog2(MP) : 1;
    localparam int unsigned BankW = bank_sel_w(NB_BANKS);
    localparam int unsigned RowW  = row_w(BANK_WORDS);

    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0] win_idx;
    logic            found;
    tcdm_req_t       sel;
    logic [RowW-1:0] row;
    logic [31:0]     mem_q [BANK_WORDS];

    // Scan ports upward from rr_ptr; first requester wins.
    always_comb begin
        int unsigned idx;
        win_o   = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < MP; i++) begin
            idx = (int'(rr_ptr_q) + i) % MP;
            if (!found && req_i[PtrW'(idx)]) begin
                found   = 1'b1;
                win_idx = PtrW'(idx);
            end
        end
        win_o[win_idx] = found;
    end

    // Pointer only moves past the winner when there was real contention.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (found && ($countones(req_i) >= 2)) begin
            rr_ptr_d = (win_idx == PtrW'(MP - 1)) ? '0 : win_idx + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) rr_ptr_q <= '0;
        else         rr_ptr_q <= rr_ptr_d;
    end

    assign sel     = reqs_i[win_idx];
    assign row     = RowW'((sel.add >> (2 + BankW)) & 32'(BANK_WORDS - 1));
    assign rdata_o = mem_q[row];

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (found && !sel.wen) begin
            for (int i = 0; i < 4; i++) begin
                if (sel.be[i]) mem_q[row][8*i +: 8] <= sel.data[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/tcdm_slave_mem.sv
// Banked, word-interleaved TCDM responder with same-cycle grant and
// one-cycle registered response.
// Ports:
//   clk_i  : clock
//   rst_ni : synchronous active-low reset; gnt forced 0 while low
//   tcdm   : tcdm_slave_mem_if.slave (req/add/wen/be/data in, gnt/r_data/r_valid out)
// Optional feature: define TCDM_SLAVE_MEM_STALL_EN to add per-port LFSR
// grant stalls (~25%).
module tcdm_slave_mem
    import tcdm_slave_mem_pkg::*;
#(
    parameter int unsigned MP         = 2,
    parameter int unsigned NB_BANKS   = 4,
    parameter int unsigned BANK_WORDS = 256,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    tcdm_slave_mem_if.slave tcdm
);
    localparam int unsigned BankIdxW = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 1;

    tcdm_req_t [MP-1:0]       req_s;
    logic [BankIdxW-1:0]      port_bank [MP];
    logic [MP-1:0]            avail;
    logic [MP-1:0]            eligible;
    logic [MP-1:0]            bank_req  [NB_BANKS];
    logic [MP-1:0]            bank_win  [NB_BANKS];
    logic [31:0]              bank_rdata[NB_BANKS];
    logic [MP-1:0]            gnt;
    logic [MP-1:0]            r_valid_q;
    logic [MP-1:0][31:0]      r_data_q, r_data_d;

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            req_s[p].add  = tcdm.add[p];
            req_s[p].wen  = tcdm.wen[p];
            req_s[p].be   = tcdm.be[p];
            req_s[p].data = tcdm.data[p];
            port_bank[p]  = BankIdxW'((tcdm.add[p] >> 2) & 32'(NB_BANKS - 1));
        end
    end

`ifdef TCDM_SLAVE_MEM_STALL_EN
    logic [15:0] lfsr_q [MP];

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++) begin
            if (!rst_ni) lfsr_q[p] <= STALL_SEED ^ 16'(p);
            else         lfsr_q[p] <= {lfsr_q[p][14:0], ^(lfsr_q[p] & StallLfsrTaps)};
        end
    end

    // A stalled port drops out of arbitration so another contender can win.
    always_comb begin
        for (int p = 0; p < MP; p++) avail[p] = (lfsr_q[p][1:0] != 2'b11);
    end
`else
    assign avail = '1;
`endif

    assign eligible = tcdm.req & avail & {MP{rst_ni}};

    always_comb begin
        for (int b = 0; b < NB_BANKS; b++) begin
            for (int p = 0; p < MP; p++) begin
                bank_req[b][p] = eligible[p] && (port_bank[p] == BankIdxW'(b));
            end
        end
    end

    for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
        tcdm_slave_mem_bank #(
            .MP         (MP),
            .NB_BANKS   (NB_BANKS),
            .BANK_WORDS (BANK_WORDS)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .req_i   (bank_req[b]),
            .reqs_i  (req_s),
            .win_o   (bank_win[b]),
            .rdata_o (bank_rdata[b])
        );
    end

    always_comb begin
        gnt = '0;
        for (int b = 0; b < NB_BANKS; b++) gnt = gnt | bank_win[b];
    end

    // Writes respond with zero data; ungranted ports hold their last data.
    always_comb begin
        r_data_d = r_data_q;
        for (int p = 0; p < MP; p++) begin
            if (gnt[p]) r_data_d[p] = tcdm.wen[p] ? bank_rdata[port_bank[p]] : 32'h0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid_q <= '0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= gnt;
            r_data_q  <= r_data_d;
        end
    end

    assign tcdm.gnt     = gnt;
    assign tcdm.r_valid = r_valid_q;
    assign tcdm.r_data  = r_data_q;
endmodule

// File: tb/tb_tcdm_slave_mem.sv
// Self-checking bench for tcdm_slave_mem (default build, no stalls).
// Reference model: flat 4 KiB word array plus a round-robin pointer per bank.
module tb_tcdm_slave_mem;
    localparam int MP = 2;
    localparam int NB = 4;
    localparam int BW = 256;
    localparam int WORDS = NB * BW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tcdm_slave_mem_if #(.MP(MP)) bus ();

    tcdm_slave_mem #(
        .MP         (MP),
        .NB_BANKS   (NB),
        .BANK_WORDS (BW),
        .STALL_SEED (16'hACE1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .tcdm   (bus)
    );

    // Stimulus for the next step
    logic [1:0]  req_s, wen_s;
    logic [31:0] add_s  [MP];
    logic [31:0] data_s [MP];
    logic [3:0]  be_s   [MP];

    // Reference model state
    logic [31:0] mem_m   [WORDS];
    int          rr_m    [NB];
    logic [31:0] rdata_m [MP];
    logic [1:0]  rvalid_m;
    logic [1:0]  exp_gnt, obs_gnt;

    int checks = 0;
    int errors = 0;

    function automatic int bank_of(input logic [31:0] a);
        return int'((a >> 2) % NB);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % WORDS);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) rr_m[b] = 0;
        for (int p = 0; p < MP; p++) rdata_m[p] = 32'h0;
        rvalid_m = 2'b00;
    endtask

    // One clock cycle: drive, check grant, advance model, check response.
    task automatic step();
        int n, p, w;
        bit taken;
        bus.req = req_s;
        bus.wen = wen_s;
        for (int q = 0; q < MP; q++) begin
            bus.add[q]  = add_s[q];
            bus.data[q] = data_s[q];
            bus.be[q]   = be_s[q];
        end
        #3;
        exp_gnt = 2'b00;
        for (int b = 0; b < NB; b++) begin
            n = 0;
            taken = 0;
            for (int q = 0; q < MP; q++) if (req_s[q] && bank_of(add_s[q]) == b) n++;
            for (int i = 0; i < MP; i++) begin
                p = (rr_m[b] + i) % MP;
                if (!taken && req_s[p] && bank_of(add_s[p]) == b) begin
                    taken = 1;
                    exp_gnt[p] = 1'b1;
                    if (n >= 2) rr_m[b] = (p + 1) % MP;
                end
            end
        end
        obs_gnt = bus.gnt;
        chk("gnt", 32'(obs_gnt), 32'(exp_gnt));
        for (int q = 0; q < MP; q++) begin
            if (exp_gnt[q]) begin
                w = word_of(add_s[q]);
                if (wen_s[q]) begin
                    rdata_m[q] = mem_m[w];
                end else begin
                    rdata_m[q] = 32'h0;
                    for (int i = 0; i < 4; i++)
                        if (be_s[q][i]) mem_m[w][8*i +: 8] = data_s[q][8*i +: 8];
                end
            end
        end
        rvalid_m = exp_gnt;
        @(posedge clk);
        #1;
        chk("r_valid", 32'(bus.r_valid), 32'(rvalid_m));
        for (int q = 0; q < MP; q++) chk($sformatf("r_data%0d", q), bus.r_data[q], rdata_m[q]);
    endtask

    task automatic set_port(input int p, input logic r, input logic [31:0] a, input logic we_n,
                            input logic [3:0] be, input logic [31:0] d);
        req_s[p]  = r;
        add_s[p]  = a;
        wen_s[p]  = we_n;
        be_s[p]   = be;
        data_s[p] = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] pattern [4];
        pattern[0] = 2'b01; pattern[1] = 2'b10; pattern[2] = 2'b01; pattern[3] = 2'b10;
        for (int w = 0; w < WORDS; w++) mem_m[w] = 32'h0;
        model_reset();

        // Reset: grant forced low even with requests present
        bus.req = 2'b11; bus.wen = 2'b11;
        bus.add[0] = 32'h0; bus.add[1] = 32'h4;
        bus.be[0] = 4'hF; bus.be[1] = 4'hF; bus.data[0] = 32'h0; bus.data[1] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_r_valid", 32'(bus.r_valid), 32'h0);
        chk("rst_r_data0", bus.r_data[0], 32'h0);
        chk("rst_r_data1", bus.r_data[1], 32'h0);
        bus.req = 2'b00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_port(1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0);

        // Write then read back
        set_port(0, 1'b1, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF); step();
        set_port(0, 1'b1, 32'h10, 1'b1, 4'hF, 32'h0); step();
        chk("t1_read", bus.r_data[0], 32'hDEADBEEF);

        // Byte enables
        set_port(0, 1'b1, 32'h20, 1'b0, 4'hF, 32'h11223344); step();
        set_port(0, 1'b1, 32'h20, 1'b0, 4'b0001, 32'h000000AA); step();
        set_port(0, 1'b1, 32'h20, 1'b1, 4'h0, 32'h0); step();
        chk("t2_be", bus.r_data[0], 32'h112233AA);

        // Be=0 write: responded to but memory untouched
        set_port(0, 1'b1, 32'h20, 1'b0, 4'h0, 32'hFFFFFFFF); step();
        set_port(0, 1'b1, 32'h20, 1'b1, 4'h0, 32'h0); step();

        // Conflict on bank 0, held four cycles
        set_port(0, 1'b1, 32'h00, 1'b1, 4'h0, 32'h0);
        set_port(1, 1'b1, 32'h40, 1'b1, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("conflict_gnt%0d", i), 32'(obs_gnt), 32'(pattern[i]));
        end

        // Different banks: both granted at once
        set_port(1, 1'b1, 32'h04, 1'b1, 4'h0, 32'h0); step();
        chk("noconf_gnt", 32'(obs_gnt), 32'h3);
        chk("noconf_rv", 32'(bus.r_valid), 32'h3);

        // Aliasing across 4 KiB
        set_port(1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0);
        set_port(0, 1'b1, 32'h1000, 1'b0, 4'hF, 32'hCAFEF00D); step();
        set_port(0, 1'b1, 32'h0000, 1'b1, 4'h0, 32'h0); step();
        chk("alias", bus.r_data[0], 32'hCAFEF00D);

        // Reset asserted in the cycle after a read grant
        step();
        chk("prerst_rv", 32'(bus.r_valid), 32'h1);
        rst_n = 1'b0;
        #3;
        chk("midrst_gnt", 32'(bus.gnt), 32'h0);
        @(posedge clk);
        #1;
        chk("midrst_rv", 32'(bus.r_valid), 32'h0);
        chk("midrst_rd", bus.r_data[0], 32'h0);
        #3;
        chk("midrst_gnt2", 32'(bus.gnt), 32'h0);
        @(posedge clk);
        #1;
        bus.req = 2'b00;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        step();
        chk("postrst_read", bus.r_data[0], 32'hCAFEF00D);

        // Fill all words with random data (ports on disjoint banks)
        for (int w = 0; w < WORDS / 2; w++) begin
            set_port(0, 1'b1, 32'(8 * w), 1'b0, 4'hF, $urandom);
            set_port(1, 1'b1, 32'(8 * w + 4), 1'b0, 4'hF, $urandom);
            step();
        end

        // Random traffic; ungranted requests keep their payload
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < MP; p++) begin
                if (!(req_s[p] && !exp_gnt[p])) begin
                    set_port(p, ($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 1),
                             4'($urandom), $urandom);
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
